// File: rtl/cmix_pkg.sv
// Shared constants for the complex mixer: mode encoding and pipeline latency helper.
package cmix_pkg;

    localparam logic CMIX_NORMAL = 1'b0;
    localparam logic CMIX_CONJ   = 1'b1;

    function automatic int cmix_latency(input int delay);
        return delay + 4;
    endfunction

endpackage

// File: rtl/cmix_round_sat.sv
// Registered round-half-up, arithmetic right shift and saturation of one channel.
// Latency 1 enabled edge; no backpressure, holds while clk_en is low.
module cmix_round_sat #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    // One guard bit beyond the wider of input/output so the rounding add cannot wrap.
    localparam int W = (IN_W > OUT_W) ? IN_W + 1 : OUT_W + 1;
    localparam logic signed [W-1:0] RND  = W'((2 ** SHIFT) / 2);
    localparam logic signed [W-1:0] MAXV = {{(W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {{(W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [W-1:0] ext;
    logic signed [W-1:0] shifted;
    logic                clip_hi;
    logic                clip_lo;

    always_comb begin
        ext     = W'(din);
        shifted = (ext + RND) >>> SHIFT;
        clip_hi = shifted > MAXV;
        clip_lo = shifted < MINV;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dout <= '0;
            sat  <= 1'b0;
        end else if (clk_en) begin
            sat <= clip_hi | clip_lo;
            if (clip_hi)
                dout <= MAXV[OUT_W-1:0];
            else if (clip_lo)
                dout <= MINV[OUT_W-1:0];
            else
                dout <= shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/cmix_pipelined.sv
// Pipelined complex mixer rf*lo or rf*conj(lo) with rounding, saturation and sticky overflow flag.
// Latency DELAY+4 enabled edges; no backpressure, clk_en low freezes every register.
module cmix_pipelined
    import cmix_pkg::*;
#(
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 16,
    parameter int DELAY  = 4,
    parameter int SHIFT  = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic                     in_valid,
    input  logic                     conj,
    input  logic signed [IWIDTH-1:0] rf_i,
    input  logic signed [IWIDTH-1:0] rf_q,
    input  logic signed [IWIDTH-1:0] lo_i,
    input  logic signed [IWIDTH-1:0] lo_q,
    output logic                     out_valid,
    output logic signed [OWIDTH-1:0] if_i,
    output logic signed [OWIDTH-1:0] if_q,
    output logic                     sat_flag
);

    localparam int PW = 2 * IWIDTH;
    localparam int SW = PW + 1;

    logic signed [IWIDTH-1:0] s0_rf_i, s0_rf_q, s0_lo_i, s0_lo_q;
    logic                     s0_conj, s0_vld;

    // Index 0 is the multiplier output stage; 1..DELAY are the retiming stages.
    logic signed [PW-1:0] ii_d [0:DELAY];
    logic signed [PW-1:0] qq_d [0:DELAY];
    logic signed [PW-1:0] iq_d [0:DELAY];
    logic signed [PW-1:0] qi_d [0:DELAY];
    logic                 conj_d [0:DELAY];
    logic                 vld_d  [0:DELAY];

    logic signed [SW-1:0] sum_i, sum_q;
    logic                 sum_vld;
    logic                 sat_i, sat_q, sat_hold;

    logic signed [PW-1:0] m_ri, m_rq, m_li, m_lq;
    logic signed [SW-1:0] x_ii, x_qq, x_iq, x_qi;

    always_comb begin
        m_ri = PW'(s0_rf_i);
        m_rq = PW'(s0_rf_q);
        m_li = PW'(s0_lo_i);
        m_lq = PW'(s0_lo_q);
        x_ii = SW'(ii_d[DELAY]);
        x_qq = SW'(qq_d[DELAY]);
        x_iq = SW'(iq_d[DELAY]);
        x_qi = SW'(qi_d[DELAY]);
    end

    // Data registers are reset too so idle outputs are deterministic after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            s0_rf_i <= '0;
            s0_rf_q <= '0;
            s0_lo_i <= '0;
            s0_lo_q <= '0;
            s0_conj <= CMIX_NORMAL;
            s0_vld  <= 1'b0;
            for (int k = 0; k <= DELAY; k++) begin
                ii_d[k]   <= '0;
                qq_d[k]   <= '0;
                iq_d[k]   <= '0;
                qi_d[k]   <= '0;
                conj_d[k] <= CMIX_NORMAL;
                vld_d[k]  <= 1'b0;
            end
            sum_i     <= '0;
            sum_q     <= '0;
            sum_vld   <= 1'b0;
            out_valid <= 1'b0;
            sat_hold  <= 1'b0;
        end else if (clk_en) begin
            s0_rf_i <= rf_i;
            s0_rf_q <= rf_q;
            s0_lo_i <= lo_i;
            s0_lo_q <= lo_q;
            s0_conj <= conj;
            s0_vld  <= in_valid;

            ii_d[0]   <= m_ri * m_li;
            qq_d[0]   <= m_rq * m_lq;
            iq_d[0]   <= m_ri * m_lq;
            qi_d[0]   <= m_rq * m_li;
            conj_d[0] <= s0_conj;
            vld_d[0]  <= s0_vld;
            for (int k = 1; k <= DELAY; k++) begin
                ii_d[k]   <= ii_d[k-1];
                qq_d[k]   <= qq_d[k-1];
                iq_d[k]   <= iq_d[k-1];
                qi_d[k]   <= qi_d[k-1];
                conj_d[k] <= conj_d[k-1];
                vld_d[k]  <= vld_d[k-1];
            end

            if (conj_d[DELAY] == CMIX_CONJ) begin
                sum_i <= x_ii + x_qq;
                sum_q <= x_qi - x_iq;
            end else begin
                sum_i <= x_ii - x_qq;
                sum_q <= x_iq + x_qi;
            end
            sum_vld <= vld_d[DELAY];

            out_valid <= sum_vld;
            sat_hold  <= sat_flag;
        end
    end

    cmix_round_sat #(.IN_W(SW), .OUT_W(OWIDTH), .SHIFT(SHIFT)) u_rs_i (
        .clock  (clock),
        .reset  (reset),
        .clk_en (clk_en),
        .din    (sum_i),
        .dout   (if_i),
        .sat    (sat_i)
    );

    cmix_round_sat #(.IN_W(SW), .OUT_W(OWIDTH), .SHIFT(SHIFT)) u_rs_q (
        .clock  (clock),
        .reset  (reset),
        .clk_en (clk_en),
        .din    (sum_q),
        .dout   (if_q),
        .sat    (sat_q)
    );

    // Flag rises in the same cycle as the clipped sample, driven only from registers.
    assign sat_flag = sat_hold | (out_valid & (sat_i | sat_q));

endmodule

// File: tb/tb_cmix_pipelined.sv
// Bench for cmix_pipelined: default build plus a SHIFT=4 build fed from the same stimulus.
module tb_cmix_pipelined;
    import cmix_pkg::*;

    logic clock = 1'b0;
    logic reset, clk_en, in_valid, conj;
    logic signed [7:0] rf_i, rf_q, lo_i, lo_q;

    logic              ov0, ov1, sf0, sf1;
    logic signed [15:0] ii0, iq0, ii1, iq1;

    always #5 clock = ~clock;

    cmix_pipelined dut0 (
        .clock(clock), .reset(reset), .clk_en(clk_en), .in_valid(in_valid), .conj(conj),
        .rf_i(rf_i), .rf_q(rf_q), .lo_i(lo_i), .lo_q(lo_q),
        .out_valid(ov0), .if_i(ii0), .if_q(iq0), .sat_flag(sf0)
    );

    cmix_pipelined #(.SHIFT(4)) dut1 (
        .clock(clock), .reset(reset), .clk_en(clk_en), .in_valid(in_valid), .conj(conj),
        .rf_i(rf_i), .rf_q(rf_q), .lo_i(lo_i), .lo_q(lo_q),
        .out_valid(ov1), .if_i(ii1), .if_q(iq1), .sat_flag(sf1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ri, rq, li, lq;
        bit cj;
        int ei, eq, ei4, eq4;
        bit esat;
    } vec_t;

    typedef struct { int i; int q; } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int round_sat(input int x, input int sh);
        int y;
        y = x;
        if (sh > 0) y = y + (1 << (sh - 1));
        y = y >>> sh;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    // Reference: plain complex arithmetic, then round/shift/saturate.
    function automatic exp_t mix(input int ri, input int rq, input int li, input int lq,
                                 input bit cj, input int sh);
        exp_t r;
        int pi, pq;
        if (!cj) begin
            pi = ri * li - rq * lq;
            pq = ri * lq + rq * li;
        end else begin
            pi = ri * li + rq * lq;
            pq = rq * li - ri * lq;
        end
        r.i = round_sat(pi, sh);
        r.q = round_sat(pq, sh);
        return r;
    endfunction

    task automatic apply_vec(input vec_t v, input string tag);
        int lat = 0;
        int pulses = 0;
        int gi = 0, gq = 0, gi4 = 0, gq4 = 0;
        rf_i = 8'(v.ri); rf_q = 8'(v.rq); lo_i = 8'(v.li); lo_q = 8'(v.lq);
        conj = v.cj; in_valid = 1'b1; clk_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            in_valid = 1'b0;
            if (ov0) begin
                pulses++;
                if (lat == 0) begin
                    lat = k; gi = ii0; gq = iq0; gi4 = ii1; gq4 = iq1;
                end
            end
        end
        chk({tag, "_latency"}, lat, cmix_latency(4));
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_if_i"}, gi, v.ei);
        chk({tag, "_if_q"}, gq, v.eq);
        chk({tag, "_if_i_sh4"}, gi4, v.ei4);
        chk({tag, "_if_q_sh4"}, gq4, v.eq4);
        chk({tag, "_sat"}, sf0, v.esat);
        chk({tag, "_sat_sh4"}, sf1, 0);
    endtask

    task automatic run_stream(input int n, input int stall_pct, input bit alt, input string tag);
        int pi0, pq0, pv0;
        exp_t e;
        for (int c = 0; c < n; c++) begin
            clk_en   = ($urandom_range(99) >= stall_pct);
            in_valid = ($urandom_range(3) != 0);
            conj     = alt ? c[0] : 1'($urandom_range(1));
            rf_i = 8'($urandom); rf_q = 8'($urandom);
            lo_i = 8'($urandom); lo_q = 8'($urandom);
            if (c >= n - 20) begin
                clk_en = 1'b1;
                in_valid = 1'b0;
            end
            pi0 = ii0; pq0 = iq0; pv0 = ov0;
            if (clk_en && in_valid) begin
                q0.push_back(mix(rf_i, rf_q, lo_i, lo_q, conj, 0));
                q1.push_back(mix(rf_i, rf_q, lo_i, lo_q, conj, 4));
            end
            tick();
            if (!clk_en) begin
                chk({tag, "_hold_i"}, ii0, pi0);
                chk({tag, "_hold_q"}, iq0, pq0);
                chk({tag, "_hold_v"}, ov0, pv0);
            end else begin
                chk({tag, "_valid_match"}, ov1, ov0);
                if (ov0) begin
                    if (q0.size() == 0) begin
                        chk({tag, "_unexpected_valid"}, 1, 0);
                    end else begin
                        e = q0.pop_front();
                        chk({tag, "_if_i"}, ii0, e.i);
                        chk({tag, "_if_q"}, iq0, e.q);
                    end
                end
                if (ov1 && q1.size() != 0) begin
                    e = q1.pop_front();
                    chk({tag, "_if_i_sh4"}, ii1, e.i);
                    chk({tag, "_if_q_sh4"}, iq1, e.q);
                end
            end
        end
        chk({tag, "_drained"}, q0.size(), 0);
        chk({tag, "_drained_sh4"}, q1.size(), 0);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        tbl[0] = '{ri:3,    rq:4,    li:2,    lq:1,    cj:0, ei:2,    eq:11,     ei4:0,  eq4:1,     esat:0};
        tbl[1] = '{ri:3,    rq:4,    li:2,    lq:1,    cj:1, ei:10,   eq:5,      ei4:1,  eq4:0,     esat:0};
        tbl[2] = '{ri:10,   rq:0,    li:13,   lq:0,    cj:0, ei:130,  eq:0,      ei4:8,  eq4:0,     esat:0};
        tbl[3] = '{ri:-10,  rq:0,    li:13,   lq:0,    cj:0, ei:-130, eq:0,      ei4:-8, eq4:0,     esat:0};
        tbl[4] = '{ri:127,  rq:-128, li:127,  lq:127,  cj:1, ei:-127, eq:-32385, ei4:-8, eq4:-2024, esat:0};
        tbl[5] = '{ri:-128, rq:-128, li:-128, lq:-128, cj:0, ei:0,    eq:32767,  ei4:0,  eq4:2048,  esat:1};

        reset = 1'b1; clk_en = 1'b1; in_valid = 1'b0; conj = 1'b0;
        rf_i = '0; rf_q = '0; lo_i = '0; lo_q = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_out_valid", ov0, 0);
        chk("reset_if_i", ii0, 0);
        chk("reset_if_q", iq0, 0);
        chk("reset_sat", sf0, 0);
        chk("reset_out_valid_sh4", ov1, 0);
        chk("reset_if_i_sh4", ii1, 0);

        for (int v = 0; v < 6; v++) apply_vec(tbl[v], $sformatf("vec%0d", v));

        // Sticky flag must survive a long run of clean valid beats.
        rf_i = 8'sd1; rf_q = 8'sd2; lo_i = 8'sd3; lo_q = 8'sd4; conj = 1'b0;
        in_valid = 1'b1;
        repeat (100) tick();
        in_valid = 1'b0;
        repeat (12) tick();
        chk("sticky_sat", sf0, 1);
        chk("sticky_sat_sh4", sf1, 0);

        // Five samples in flight, then a single reset edge must discard them all.
        rf_i = 8'sd5; rf_q = -8'sd7; lo_i = 8'sd9; lo_q = 8'sd2;
        in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_out_valid", ov0, 0);
        chk("midreset_if_i", ii0, 0);
        chk("midreset_if_q", iq0, 0);
        chk("midreset_sat", sf0, 0);
        apply_vec(tbl[0], "post_reset");

        run_stream(60, 0, 1'b1, "alt_conj");
        run_stream(800, 30, 1'b0, "rand_stall");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
